bloom_filter_loader: RTL and testbench

// - Write side of the PacketSentinel Bloom filter: inserts (src_ip, dest_ip) pairs into the shared
//   bit array that bloom_filter queries. Also clears the whole array on command.
// - Computes the same two hash indices as the query path, then does a read-modify-write on each
//   bit through a word-wide synchronous RAM port. Sits between the rule-programming path and the array RAM.

---
 rtl/bloom_filter_loader_if.sv | 27 ++
 rtl/bloom_filter_loader.sv | 201 ++++++++++++++++++++
 tb/tb_bloom_filter_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bloom_filter_loader_if.sv
// Insert-request and bit-array RAM signal bundle for the Bloom filter loader.
// Ports: ins_valid/ins_ready/src_ip/dest_ip (insert handshake), mem_* (word-wide sync RAM port).
// slave modport = loader view; master modport = the rule-programming path plus the RAM.
interface bloom_filter_loader_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 5
);
   logic              ins_valid;
   logic              ins_ready;
   logic [31:0]       src_ip;
   logic [31:0]       dest_ip;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_rd_data;
   logic              mem_wr_en;
   logic [WORD_W-1:0] mem_wr_data;

   modport master (
      output ins_valid, src_ip, dest_ip, mem_rd_data,
      input  ins_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
   );

   modport slave (
      input  ins_valid, src_ip, dest_ip, mem_rd_data,
      output ins_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
   );
endinterface

// File: rtl/bloom_filter_loader.sv
// Purpose: Bloom filter write side; hashes (src_ip, dest_ip) to two bits and sets each by RAM read-modify-write; clears the array on clr_req.
// Latency: insert accepted at T, writes at T+2 and T+4, ins_done at T+5; clear takes 2^ADDR_W write cycles plus a done cycle.
// Backpressure: ins_ready drops for the whole insert/clear; a held clr_req waits for the running insert and beats a same-cycle insert.
// Ports: clk, rst_n (async active-low); bus (slave: insert handshake + RAM port); clr_req;
//        busy, ins_done, clr_done, ins_count; dup_count when BLOOM_LOADER_DUP_COUNT_EN is defined.
// Optional feature macro: BLOOM_LOADER_DUP_COUNT_EN (counts inserts whose two bits were both already set).
module bloom_filter_loader #(
   parameter int BIT_ARRAY_SIZE = 1024,
   parameter int HASH_WIDTH     = $clog2(BIT_ARRAY_SIZE),
   parameter int WORD_W         = 32,
   parameter int ADDR_W         = HASH_WIDTH - $clog2(WORD_W)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bloom_filter_loader_if.slave bus,
   input  logic                 clr_req,
   output logic                 busy,
   output logic                 ins_done,
   output logic                 clr_done,
   output logic [15:0]          ins_count
`ifdef BLOOM_LOADER_DUP_COUNT_EN
   ,
   output logic [15:0]          dup_count
`endif
);
   localparam int HW    = HASH_WIDTH;
   localparam int BIT_W = $clog2(WORD_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD1,
      S_WR1,
      S_RD2,
      S_WR2,
      S_CLEAR
   } state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     h1_q, h1_d;
   logic [HW-1:0]     h2_q, h2_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [15:0]       ins_count_q, ins_count_d;
   logic              ins_done_q, ins_done_d;
   logic              clr_done_q, clr_done_d;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
   logic              dup1_q, dup1_d;
   logic [15:0]       dup_count_q, dup_count_d;
`endif

   // Hash of the offered pair; must match the query path bit-for-bit.
   logic [31:0]       hash_x;
   logic [HW-1:0]     h1_new;
   logic [HW-1:0]     h2_new;
   logic              unused_hash_bits;

   assign hash_x = bus.src_ip ^ {bus.dest_ip[15:0], bus.dest_ip[31:16]};
   assign h1_new = hash_x[HW-1:0] ^ hash_x[31:32-HW];
   assign h2_new = bus.src_ip[HW-1:0] + bus.dest_ip[HW-1:0] + bus.dest_ip[31:32-HW];
   // Middle bits of the IPs do not feed either hash.
   assign unused_hash_bits = ^{hash_x, bus.src_ip, bus.dest_ip};

   logic [ADDR_W-1:0] a1, a2;
   logic [BIT_W-1:0]  b1, b2;
   assign a1 = h1_q[HW-1:BIT_W];
   assign b1 = h1_q[BIT_W-1:0];
   assign a2 = h2_q[HW-1:BIT_W];
   assign b2 = h2_q[BIT_W-1:0];

   logic              ins_ready_c;
   logic              rd_en_c;
   logic              wr_en_c;
   logic [ADDR_W-1:0] addr_c;
   logic [WORD_W-1:0] wr_data_c;

   always_comb begin
      state_d     = state_q;
      h1_d        = h1_q;
      h2_d        = h2_q;
      clr_addr_d  = clr_addr_q;
      ins_count_d = ins_count_q;
      ins_done_d  = 1'b0;
      clr_done_d  = 1'b0;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
      dup1_d      = dup1_q;
      dup_count_d = dup_count_q;
`endif
      ins_ready_c = 1'b0;
      rd_en_c     = 1'b0;
      wr_en_c     = 1'b0;
      addr_c      = '0;
      wr_data_c   = '0;

      case (state_q)
         S_IDLE: begin
            ins_ready_c = !clr_req;
            if (clr_req) begin
               clr_addr_d = '0;
               state_d    = S_CLEAR;
            end else if (bus.ins_valid) begin
               h1_d    = h1_new;
               h2_d    = h2_new;
               state_d = S_RD1;
            end
         end
         S_RD1: begin
            rd_en_c = 1'b1;
            addr_c  = a1;
            state_d = S_WR1;
         end
         S_WR1: begin
            wr_en_c   = 1'b1;
            addr_c    = a1;
            wr_data_c = bus.mem_rd_data | (WORD_W'(1) << b1);
`ifdef BLOOM_LOADER_DUP_COUNT_EN
            dup1_d    = bus.mem_rd_data[b1];
`endif
            state_d   = S_RD2;
         end
         S_RD2: begin
            // The RAM is write-before-read, so if a2==a1 this returns the WR1 word.
            rd_en_c = 1'b1;
            addr_c  = a2;
            state_d = S_WR2;
         end
         S_WR2: begin
            wr_en_c    = 1'b1;
            addr_c     = a2;
            wr_data_c  = bus.mem_rd_data | (WORD_W'(1) << b2);
            ins_done_d = 1'b1;
            if (ins_count_q != 16'hFFFF) begin
               ins_count_d = ins_count_q + 16'd1;
            end
`ifdef BLOOM_LOADER_DUP_COUNT_EN
            if (dup1_q && bus.mem_rd_data[b2] && (dup_count_q != 16'hFFFF)) begin
               dup_count_d = dup_count_q + 16'd1;
            end
`endif
            state_d    = S_IDLE;
         end
         S_CLEAR: begin
            wr_en_c    = 1'b1;
            addr_c     = clr_addr_q;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == {ADDR_W{1'b1}}) begin
               ins_count_d = '0;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
               dup_count_d = '0;
`endif
               clr_done_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         h1_q        <= '0;
         h2_q        <= '0;
         clr_addr_q  <= '0;
         ins_count_q <= '0;
         ins_done_q  <= 1'b0;
         clr_done_q  <= 1'b0;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
         dup1_q      <= 1'b0;
         dup_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         h1_q        <= h1_d;
         h2_q        <= h2_d;
         clr_addr_q  <= clr_addr_d;
         ins_count_q <= ins_count_d;
         ins_done_q  <= ins_done_d;
         clr_done_q  <= clr_done_d;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
         dup1_q      <= dup1_d;
         dup_count_q <= dup_count_d;
`endif
      end
   end

   // RAM strobes decode straight from state so an async reset kills a pending write at once.
   assign bus.ins_ready   = ins_ready_c;
   assign bus.mem_rd_en   = rd_en_c;
   assign bus.mem_wr_en   = wr_en_c;
   assign bus.mem_addr    = addr_c;
   assign bus.mem_wr_data = wr_data_c;

   assign busy      = (state_q != S_IDLE);
   assign ins_done  = ins_done_q;
   assign clr_done  = clr_done_q;
   assign ins_count = ins_count_q;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
   assign dup_count = dup_count_q;
`endif
endmodule

// File: tb/tb_bloom_filter_loader.sv
// Directed bench for bloom_filter_loader (1024 bits, 32-bit words) with a write-before-read RAM model.
// Ports: drives the insert side and RAM read data through the interface, clr_req and rst_n directly.
// Build with BLOOM_LOADER_DUP_COUNT_EN defined to also cover dup_count.
module tb_bloom_filter_loader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_req;
   logic        busy;
   logic        ins_done;
   logic        clr_done;
   logic [15:0] ins_count;
`ifdef BLOOM_LOADER_DUP_COUNT_EN
   logic [15:0] dup_count;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int strobe_clash = 0;
   int idle_bad     = 0;

   bloom_filter_loader_if #(.WORD_W(32), .ADDR_W(5)) bus ();

   bloom_filter_loader #(.BIT_ARRAY_SIZE(1024), .WORD_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .clr_req   (clr_req),
      .busy      (busy),
      .ins_done  (ins_done),
      .clr_done  (clr_done),
      .ins_count (ins_count)
`ifdef BLOOM_LOADER_DUP_COUNT_EN
      ,
      .dup_count (dup_count)
`endif
   );

   always #5 clk = ~clk;

   // RAM model: synchronous read, one-cycle latency; a write is visible to a read issued the next cycle.
   logic [31:0] mem [32];
   logic        pre_en;
   logic [4:0]  pre_addr;
   logic [31:0] pre_dat;

   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
      else if (pre_en)   mem[pre_addr] <= pre_dat;
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
   end

   always @(negedge clk) begin
      if (bus.mem_rd_en && bus.mem_wr_en) strobe_clash++;
      if (!busy && (bus.mem_addr !== 5'd0 || bus.mem_wr_data !== 32'd0)) idle_bad++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      pre_addr = a; pre_dat = d; pre_en = 1'b1;
      step();
      pre_en = 1'b0;
   endtask

   // Enters at the negedge of cycle T, returns at the negedge of T+1.
   task automatic issue(input logic [31:0] s, input logic [31:0] d);
      bus.src_ip = s; bus.dest_ip = d; bus.ins_valid = 1'b1;
      step();
      bus.ins_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr_req = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_dat = '0;
      bus.ins_valid = 1'b0; bus.src_ip = '0; bus.dest_ip = '0;
      step(2);
      vectors++; if (bus.ins_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ins_ready got %b want 1", bus.ins_ready); end
      vectors++; if ({busy, ins_done, clr_done} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {busy, ins_done, clr_done}); end
      vectors++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== 39'd0) begin miscompares++; $display("FAIL rst_mem_port got %h want 0", {bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data}); end
      vectors++; if (ins_count !== 16'd0) begin miscompares++; $display("FAIL rst_ins_count got %h want 0", ins_count); end
      rst_n = 1'b1;
      step(3);
      vectors++; if ({bus.ins_ready, busy, bus.mem_rd_en, bus.mem_wr_en} !== 4'b1000) begin miscompares++; $display("FAIL idle_after_rst got %b want 1000", {bus.ins_ready, busy, bus.mem_rd_en, bus.mem_wr_en}); end
   endtask

   task automatic test_insert();
      preload(5'd4, 32'h8000_0000);
      preload(5'd24, 32'h0);
      vectors++; if (bus.ins_ready !== 1'b1) begin miscompares++; $display("FAIL ins_ready_T got %b want 1", bus.ins_ready); end
      issue(32'h0A00_0001, 32'hC0A8_0001);
      vectors++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, busy, bus.ins_ready} !== {2'b10, 5'd4, 2'b10}) begin miscompares++; $display("FAIL ins_rd1 got %b want 1000100110", {bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, busy, bus.ins_ready}); end
      step();
      vectors++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr} !== {2'b01, 5'd4}) begin miscompares++; $display("FAIL ins_wr1_strobe got %b want 0100100", {bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr}); end
      vectors++; if (bus.mem_wr_data !== 32'h8000_0002) begin miscompares++; $display("FAIL ins_wr1_data got %h want 80000002", bus.mem_wr_data); end
      step();
      vectors++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr} !== {2'b10, 5'd24}) begin miscompares++; $display("FAIL ins_rd2 got %b want 1011000", {bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr}); end
      step();
      vectors++; if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, ins_done} !== {1'b1, 5'd24, 32'h10, 1'b0}) begin miscompares++; $display("FAIL ins_wr2 got %h want %h", {bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, ins_done}, {1'b1, 5'd24, 32'h10, 1'b0}); end
      step();
      vectors++; if ({ins_done, busy, bus.ins_ready} !== 3'b101) begin miscompares++; $display("FAIL ins_done_T5 got %b want 101", {ins_done, busy, bus.ins_ready}); end
      vectors++; if (ins_count !== 16'd1) begin miscompares++; $display("FAIL ins_count_1 got %0d want 1", ins_count); end
      vectors++; if (mem[4] !== 32'h8000_0002 || mem[24] !== 32'h10) begin miscompares++; $display("FAIL ins_ram got %h/%h want 80000002/00000010", mem[4], mem[24]); end
      step();
      vectors++; if (ins_done !== 1'b0) begin miscompares++; $display("FAIL ins_done_pulse got %b want 0", ins_done); end
   endtask

   // h1=0x0A6, h2=0x0A5: same word 5, bits 6 and 5.
   task automatic test_same_word();
      preload(5'd5, 32'h0100_0000);
      issue(32'h00C0_00A5, 32'h0);
      vectors++; if (bus.mem_addr !== 5'd5) begin miscompares++; $display("FAIL same_rd1_addr got %0d want 5", bus.mem_addr); end
      step();
      vectors++; if (bus.mem_wr_data !== 32'h0100_0040) begin miscompares++; $display("FAIL same_wr1_data got %h want 01000040", bus.mem_wr_data); end
      step(2);
      vectors++; if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== {1'b1, 5'd5, 32'h0100_0060}) begin miscompares++; $display("FAIL same_wr2 got %h want %h", {bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data}, {1'b1, 5'd5, 32'h0100_0060}); end
      step();
      vectors++; if (mem[5] !== 32'h0100_0060) begin miscompares++; $display("FAIL same_ram got %h want 01000060", mem[5]); end
      vectors++; if (ins_count !== 16'd2) begin miscompares++; $display("FAIL same_ins_count got %0d want 2", ins_count); end
   endtask

   task automatic test_clear_priority();
      logic seen_bad;
      clr_req = 1'b1;
      bus.src_ip = 32'h1234_5678; bus.dest_ip = 32'h9ABC_DEF0; bus.ins_valid = 1'b1;
      #1;
      vectors++; if (bus.ins_ready !== 1'b0) begin miscompares++; $display("FAIL clr_prio_ready got %b want 0", bus.ins_ready); end
      step();
      clr_req = 1'b0; bus.ins_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         vectors++; if ({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wr_data, ins_done, clr_done} !== {2'b10, 5'(i), 32'h0, 2'b00}) begin miscompares++; $display("FAIL clr_write_%0d got %h want %h", i, {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wr_data}, {2'b10, 5'(i), 32'h0}); end
         step();
      end
      vectors++; if ({clr_done, busy, ins_done} !== 3'b100) begin miscompares++; $display("FAIL clr_done_pulse got %b want 100", {clr_done, busy, ins_done}); end
      vectors++; if (ins_count !== 16'd0) begin miscompares++; $display("FAIL clr_ins_count got %0d want 0", ins_count); end
      step();
      vectors++; if ({clr_done, bus.ins_ready} !== 2'b01) begin miscompares++; $display("FAIL clr_done_after got %b want 01", {clr_done, bus.ins_ready}); end
      seen_bad = 1'b0;
      for (int i = 0; i < 32; i++) if (mem[i] !== 32'h0) seen_bad = 1'b1;
      vectors++; if (seen_bad !== 1'b0) begin miscompares++; $display("FAIL clr_ram_zero got %b want 0", seen_bad); end
   endtask

   task automatic test_clear_held();
      int  waited;
      logic found;
      issue(32'h0A00_0001, 32'hC0A8_0001);
      clr_req = 1'b1;
      step(3);
      vectors++; if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== {1'b1, 5'd24, 32'h10}) begin miscompares++; $display("FAIL held_wr2 got %h want %h", {bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data}, {1'b1, 5'd24, 32'h10}); end
      step();
      vectors++; if ({ins_done, busy, bus.ins_ready} !== 3'b100) begin miscompares++; $display("FAIL held_done got %b want 100", {ins_done, busy, bus.ins_ready}); end
      vectors++; if (ins_count !== 16'd1) begin miscompares++; $display("FAIL held_ins_count got %0d want 1", ins_count); end
      step();
      vectors++; if ({busy, bus.mem_wr_en, bus.mem_addr} !== {2'b11, 5'd0}) begin miscompares++; $display("FAIL held_clear_start got %b want 1100000", {busy, bus.mem_wr_en, bus.mem_addr}); end
      clr_req = 1'b0;
      found = 1'b0; waited = 0;
      while (!found && waited < 40) begin
         step();
         waited++;
         if (clr_done === 1'b1) found = 1'b1;
      end
      vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL held_clr_timeout got %b want 1", found); end
      vectors++; if (ins_count !== 16'd0) begin miscompares++; $display("FAIL held_clr_count got %0d want 0", ins_count); end
      step();
   endtask

   task automatic test_reset_mid_insert();
      preload(5'd4, 32'h8000_0000);
      issue(32'h0A00_0001, 32'hC0A8_0001);
      step();
      vectors++; if (bus.mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_in_wr1 got %b want 1", bus.mem_wr_en); end
      rst_n = 1'b0;
      #1;
      vectors++; if ({bus.mem_wr_en, bus.mem_rd_en, busy, bus.ins_ready, bus.mem_addr, bus.mem_wr_data} !== {4'b0001, 5'd0, 32'h0}) begin miscompares++; $display("FAIL mid_rst_outputs got %h want %h", {bus.mem_wr_en, bus.mem_rd_en, busy, bus.ins_ready, bus.mem_addr, bus.mem_wr_data}, {4'b0001, 5'd0, 32'h0}); end
      step();
      vectors++; if (mem[4] !== 32'h8000_0000) begin miscompares++; $display("FAIL mid_no_write got %h want 80000000", mem[4]); end
      rst_n = 1'b1;
      step(6);
      vectors++; if ({ins_count, ins_done, busy} !== 18'd0) begin miscompares++; $display("FAIL mid_count got %h want 0", {ins_count, ins_done, busy}); end
   endtask

`ifdef BLOOM_LOADER_DUP_COUNT_EN
   task automatic test_dup_count();
      preload(5'd4, 32'h8000_0000);
      preload(5'd24, 32'h0);
      issue(32'h0A00_0001, 32'hC0A8_0001);
      step(4);
      vectors++; if ({dup_count, ins_count} !== {16'd0, 16'd1}) begin miscompares++; $display("FAIL dup_first got %h want 00000001", {dup_count, ins_count}); end
      issue(32'h0A00_0001, 32'hC0A8_0001);
      step(4);
      vectors++; if ({dup_count, ins_count} !== {16'd1, 16'd2}) begin miscompares++; $display("FAIL dup_second got %h want 00010002", {dup_count, ins_count}); end
   endtask
`endif

   initial begin
      test_reset();
      test_insert();
      test_same_word();
      test_clear_priority();
      test_clear_held();
      test_reset_mid_insert();
`ifdef BLOOM_LOADER_DUP_COUNT_EN
      test_dup_count();
`endif
      vectors++; if (strobe_clash !== 0) begin miscompares++; $display("FAIL rd_wr_overlap got %0d want 0", strobe_clash); end
      vectors++; if (idle_bad !== 0) begin miscompares++; $display("FAIL idle_port_nonzero got %0d want 0", idle_bad); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
